// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SLICE_W = 4;

    function automatic int n_slices(input int width, input int slice = SLICE_W);
        return width / slice;
    endfunction

endpackage

// File: rtl/slice_sub4.sv
// Combinational W-bit lookahead slice computing a + nb + cin.
// With SUB_FLAGS_EN defined it also exports the carry into its top bit.
module slice_sub4
    import sub_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] nb,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
`ifdef SUB_FLAGS_EN
    ,
    output logic         c_msb_in
`endif
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & nb;
    assign p = a ^ nb;

    // Each carry is the OR of every generate term propagated through the bits above it.
    always_comb begin
        logic pp;
        // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
        c  = '0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= W; i++) begin
            c[i] = g[i-1];
            pp   = p[i-1];
            for (int j = i - 2; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (cin & pp);
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];
`ifdef SUB_FLAGS_EN
    assign c_msb_in = c[W-1];
`endif

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one SLICE-bit slice per clock, valid/ready on both sides.
// Define SUB_FLAGS_EN to add the registered zero/neg/ovf result flags.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int N      = n_slices(WIDTH, SLICE);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be an integer multiple of SLICE");
    end

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    nb_q;
    logic                carry_q;
    logic [BASE_W-1:0]   base;
    logic [SLICE-1:0]    s_sl;
    logic                cout_sl;
    logic [WIDTH-1:0]    diff_next;
`ifdef SUB_FLAGS_EN
    logic                c_msb_sl;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign base      = BASE_W'(int'(idx) * SLICE);

    // Single slice shared across all steps; the index selects which operand bits it sees.
    slice_sub4 #(.W(SLICE)) u_slice (
        .a        (a_q[base +: SLICE]),
        .nb       (nb_q[base +: SLICE]),
        .cin      (carry_q),
        .s        (s_sl),
        .cout     (cout_sl)
`ifdef SUB_FLAGS_EN
        ,
        .c_msb_in (c_msb_sl)
`endif
    );

    always_comb begin
        diff_next = diff;
        diff_next[base +: SLICE] = s_sl;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            // NOTE: operand copies are reset too, so nothing observable ever depends on power-up contents.
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        nb_q    <= ~b;
                        carry_q <= ~bin;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    diff    <= diff_next;
                    carry_q <= cout_sl;
                    if (idx == LAST) begin
                        bout  <= ~cout_sl;
`ifdef SUB_FLAGS_EN
                        zero  <= (diff_next == '0);
                        neg   <= s_sl[SLICE-1];
                        ovf   <= cout_sl ^ c_msb_sl;
`endif
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
